// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: default widths, PC increment
// and the width of occupancy/credit counters sized for DEPTH entries.
package fetch_pkg;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam int PC_STEP        = 4;

  // Counters must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundles around the fetch stage: the instruction-memory request/response
// channel and the valid/ready channel toward decode.
interface fetch_mem_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = fetch_pkg::DATA_W_DEFAULT
);
  logic              imem_req_valid_out;
  logic              imem_req_ready_in;
  logic [ADDR_W-1:0] imem_req_addr_out;
  logic              imem_rsp_valid_in;
  logic [DATA_W-1:0] imem_rsp_data_in;

  modport master (
    output imem_req_valid_out, imem_req_addr_out,
    input  imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in
  );
  modport slave (
    input  imem_req_valid_out, imem_req_addr_out,
    output imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in
  );
endinterface

interface fetch_dec_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = fetch_pkg::DATA_W_DEFAULT
);
  logic              instr_valid_out;
  logic              instr_ready_in;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc_out;

  modport master (
    output instr_valid_out, instr_out, instr_pc_out,
    input  instr_ready_in
  );
  modport slave (
    input  instr_valid_out, instr_out, instr_pc_out,
    output instr_ready_in
  );
endinterface

// File: rtl/instr_fetch_unit_fifo_sync.sv
// Synchronous circular FIFO with push/pop/clear, occupancy count and a
// combinational head. Storage is not reset; only pointers and count are.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count < FULL) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order imem requests at pc_in, tags responses with their
// PC, buffers them for decode and discards in-flight fetches on flush.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance_out,
  input  logic              flush_in,
  fetch_mem_if.master       mem,
  fetch_dec_if.master       dec
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam int BW = DATA_W + ADDR_W;

  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     tag_cnt;
  logic [CW-1:0]     buf_cnt;
  logic [CW-1:0]     out_cnt_rsp;
  logic [CW:0]       credit_used;
  logic [ADDR_W-1:0] tag_head;
  logic [BW-1:0]     buf_head;
  logic              req_valid;
  logic              accept;
  logic              rsp_ok;
  logic              rsp_drop;
  logic              rsp_live;
  logic              dec_fire;

  // Credit is reserved at issue, so every accepted request has a buffer slot.
  always_comb begin
    credit_used = {1'b0, out_cnt} + {1'b0, buf_cnt};
    req_valid   = rst_n_in && !flush_in && (credit_used < DEPTH_C);
    accept      = req_valid && mem.imem_req_ready_in;
    rsp_ok      = mem.imem_rsp_valid_in && (out_cnt != '0);
    rsp_drop    = rsp_ok && (drop_cnt != '0);
    rsp_live    = rsp_ok && (drop_cnt == '0) && (tag_cnt != '0);
    out_cnt_rsp = out_cnt - CW'(rsp_ok);
    dec_fire    = dec.instr_valid_out && dec.instr_ready_in;
  end

  assign mem.imem_req_valid_out = req_valid;
  assign mem.imem_req_addr_out  = pc_in;
  assign pc_advance_out         = accept;

  // Outstanding-request bookkeeping; on flush every remaining response is doomed.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (flush_in) begin
      out_cnt  <= out_cnt_rsp;
      drop_cnt <= out_cnt_rsp;
    end else begin
      out_cnt  <= out_cnt_rsp + CW'(accept);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
  end

  fifo_sync #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (accept),
    .push_data (pc_in),
    .pop       (rsp_live),
    .clear     (flush_in),
    .count     (tag_cnt),
    .head      (tag_head)
  );

  fifo_sync #(.WIDTH(BW), .DEPTH(DEPTH)) u_instr_buf (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (rsp_live),
    .push_data ({mem.imem_rsp_data_in, tag_head}),
    .pop       (dec_fire),
    .clear     (flush_in),
    .count     (buf_cnt),
    .head      (buf_head)
  );

  // Head fields are forced to zero while empty so reset shows clean outputs.
  assign dec.instr_valid_out = (buf_cnt != '0);
  assign dec.instr_out       = dec.instr_valid_out ? buf_head[ADDR_W +: DATA_W] : '0;
  assign dec.instr_pc_out    = dec.instr_valid_out ? buf_head[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable in-order memory
// whose data word is address + 0x13, and a PC register driven by pc_advance_out.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          pc_adv;
  logic [AW-1:0] pc = '0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;
  logic          adv_s = 1'b0;

  fetch_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();
  fetch_dec_if #(.ADDR_W(AW), .DATA_W(DW)) dec_bus ();

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .pc_in          (pc),
    .pc_advance_out (pc_adv),
    .flush_in       (flush),
    .mem            (mem_bus),
    .dec            (dec_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PC register upstream of the fetch stage.
  always @(negedge clk) adv_s <= pc_adv;
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (adv_s) pc <= pc + AW'(PC_STEP);
  end

  // In-order memory: accepts recorded mid-cycle, responses driven just after the edge.
  int            mem_lat = 1;
  bit            spur_req = 1'b0;
  int            pend_due[$];
  logic [AW-1:0] pend_addr[$];
  initial begin
    mem_bus.imem_rsp_valid_in = 1'b0;
    mem_bus.imem_rsp_data_in  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_bus.imem_req_valid_out && mem_bus.imem_req_ready_in) begin
        pend_due.push_back(cyc + mem_lat);
        pend_addr.push_back(mem_bus.imem_req_addr_out);
      end
      @(posedge clk);
      #2;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_bus.imem_rsp_valid_in = 1'b1;
        mem_bus.imem_rsp_data_in  = pend_addr[0] + 32'h13;
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else if (spur_req) begin
        mem_bus.imem_rsp_valid_in = 1'b1;
        mem_bus.imem_rsp_data_in  = 32'hDEAD_BEEF;
      end else begin
        mem_bus.imem_rsp_valid_in = 1'b0;
        mem_bus.imem_rsp_data_in  = '0;
      end
    end
  end

  // Delivery and accept monitor.
  logic [AW-1:0] got_pc[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int            acc_n = 0;
  always @(negedge clk) begin
    if (rst_n && dec_bus.instr_valid_out && dec_bus.instr_ready_in) begin
      got_pc.push_back(dec_bus.instr_pc_out);
      got_data.push_back(dec_bus.instr_out);
      got_cyc.push_back(cyc);
    end
    if (rst_n && mem_bus.imem_req_valid_out && mem_bus.imem_req_ready_in) acc_n <= acc_n + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int lat);
    tick();
    mem_bus.imem_req_ready_in = 1'b0;
    dec_bus.instr_ready_in    = 1'b1;
    flush = 1'b0;
    repeat (12) tick();
    mem_lat = lat;
  endtask

  task automatic load_pc(input logic [AW-1:0] v);
    tick();
    pc_load = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic wait_got(input int want, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (got_pc.size() >= want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_bus.imem_req_ready_in = 1'b1;
    dec_bus.instr_ready_in = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b0) $display("FAIL rst_req_valid: got %0h expected 0", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (pc_adv !== 1'b0) $display("FAIL rst_pc_advance: got %0h expected 0", pc_adv); else n_pass++;
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL rst_instr_valid: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    n_chk++; if (dec_bus.instr_out !== 32'h0) $display("FAIL rst_instr: got %h expected 00000000", dec_bus.instr_out); else n_pass++;
    n_chk++; if (dec_bus.instr_pc_out !== 32'h0) $display("FAIL rst_instr_pc: got %h expected 00000000", dec_bus.instr_pc_out); else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b1) $display("FAIL first_req_valid: got %0h expected 1", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_addr_out !== 32'h0) $display("FAIL first_req_addr: got %h expected 00000000", mem_bus.imem_req_addr_out); else n_pass++;
    n_chk++; if (pc_adv !== 1'b1) $display("FAIL first_pc_advance: got %0h expected 1", pc_adv); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL first_latency_early: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    tick();
    dec_bus.instr_ready_in = 1'b1;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_valid_out !== 1'b1) $display("FAIL first_instr_valid: got %0h expected 1", dec_bus.instr_valid_out); else n_pass++;
    n_chk++; if (dec_bus.instr_out !== 32'h0000_0013) $display("FAIL first_instr: got %h expected 00000013", dec_bus.instr_out); else n_pass++;
    n_chk++; if (dec_bus.instr_pc_out !== 32'h0) $display("FAIL first_instr_pc: got %h expected 00000000", dec_bus.instr_pc_out); else n_pass++;
  endtask

  task automatic test_streaming();
    int base;
    bit ok;
    idle(1);
    load_pc(32'h100);
    base = got_pc.size();
    mem_bus.imem_req_ready_in = 1'b1;
    wait_got(base + 8, 30, ok);
    n_chk++; if (!ok) $display("FAIL stream_timeout: got %0d instrs expected 8", got_pc.size() - base); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        n_chk++; if (got_pc[base+i] !== 32'h100 + 32'(4*i)) $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_pc[base+i], 32'h100 + 32'(4*i)); else n_pass++;
        n_chk++; if (got_data[base+i] !== 32'h113 + 32'(4*i)) $display("FAIL stream_data[%0d]: got %h expected %h", i, got_data[base+i], 32'h113 + 32'(4*i)); else n_pass++;
      end
      for (int i = 1; i < 8; i++) begin
        n_chk++; if (got_cyc[base+i] - got_cyc[base+i-1] != 1) $display("FAIL stream_gap[%0d]: got %0d cycles expected 1", i, got_cyc[base+i] - got_cyc[base+i-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int a0;
    bit ok;
    idle(1);
    load_pc(32'h300);
    dec_bus.instr_ready_in = 1'b0;
    base = got_pc.size();
    a0 = acc_n;
    mem_bus.imem_req_ready_in = 1'b1;
    repeat (10) tick();
    n_chk++; if (acc_n - a0 != 4) $display("FAIL bp_accepts: got %0d expected 4", acc_n - a0); else n_pass++;
    n_chk++; if (got_pc.size() != base) $display("FAIL bp_no_delivery: got %0d expected 0", got_pc.size() - base); else n_pass++;
    @(negedge clk);
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b0) $display("FAIL bp_req_valid: got %0h expected 0", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (dec_bus.instr_pc_out !== 32'h300) $display("FAIL bp_head_pc: got %h expected 00000300", dec_bus.instr_pc_out); else n_pass++;
    tick();
    mem_bus.imem_req_ready_in = 1'b0;
    dec_bus.instr_ready_in = 1'b1;
    wait_got(base + 4, 12, ok);
    n_chk++; if (!ok) $display("FAIL bp_drain_timeout: got %0d instrs expected 4", got_pc.size() - base); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (got_pc[base+i] !== 32'h300 + 32'(4*i)) $display("FAIL bp_pc[%0d]: got %h expected %h", i, got_pc[base+i], 32'h300 + 32'(4*i)); else n_pass++;
        n_chk++; if (got_data[base+i] !== 32'h313 + 32'(4*i)) $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[base+i], 32'h313 + 32'(4*i)); else n_pass++;
      end
    end
    repeat (4) tick();
    n_chk++; if (got_pc.size() != base + 4) $display("FAIL bp_extra: got %0d instrs expected 4", got_pc.size() - base); else n_pass++;
  endtask

  task automatic test_flush_inflight();
    int base;
    int fl_cyc;
    bit ok;
    idle(3);
    load_pc(32'h400);
    base = got_pc.size();
    dec_bus.instr_ready_in = 1'b0;
    mem_bus.imem_req_ready_in = 1'b1;
    tick();
    mem_bus.imem_req_ready_in = 1'b0;
    tick();
    mem_bus.imem_req_ready_in = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'h200;
    fl_cyc = cyc;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_pc_out !== 32'h400) $display("FAIL fl_pre_head_pc: got %h expected 00000400", dec_bus.instr_pc_out); else n_pass++;
    n_chk++; if (dec_bus.instr_out !== 32'h413) $display("FAIL fl_pre_head_data: got %h expected 00000413", dec_bus.instr_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b0) $display("FAIL fl_req_valid: got %0h expected 0", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (pc_adv !== 1'b0) $display("FAIL fl_pc_advance: got %0h expected 0", pc_adv); else n_pass++;
    tick();
    flush = 1'b0;
    pc_load = 1'b0;
    dec_bus.instr_ready_in = 1'b1;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL fl_buf_empty: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b1) $display("FAIL fl_refetch_valid: got %0h expected 1", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_addr_out !== 32'h200) $display("FAIL fl_refetch_addr: got %h expected 00000200", mem_bus.imem_req_addr_out); else n_pass++;
    wait_got(base + 1, 20, ok);
    n_chk++; if (!ok) $display("FAIL fl_timeout: got %0d instrs expected 1", got_pc.size() - base); else n_pass++;
    if (ok) begin
      n_chk++; if (got_pc[base] !== 32'h200) $display("FAIL fl_first_pc: got %h expected 00000200", got_pc[base]); else n_pass++;
      n_chk++; if (got_data[base] !== 32'h213) $display("FAIL fl_first_data: got %h expected 00000213", got_data[base]); else n_pass++;
      n_chk++; if (got_cyc[base] != fl_cyc + 5) $display("FAIL fl_first_cycle: got %0d expected %0d", got_cyc[base], fl_cyc + 5); else n_pass++;
    end
  endtask

  task automatic test_flush_with_rsp();
    int base;
    int fl_cyc;
    bit ok;
    idle(3);
    load_pc(32'h480);
    base = got_pc.size();
    dec_bus.instr_ready_in = 1'b0;
    mem_bus.imem_req_ready_in = 1'b1;
    tick();
    tick();
    tick();
    mem_bus.imem_req_ready_in = 1'b0;
    tick();
    mem_bus.imem_req_ready_in = 1'b1;
    flush = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'h500;
    fl_cyc = cyc;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_pc_out !== 32'h480) $display("FAIL flr_pre_head_pc: got %h expected 00000480", dec_bus.instr_pc_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b0) $display("FAIL flr_req_valid: got %0h expected 0", mem_bus.imem_req_valid_out); else n_pass++;
    tick();
    flush = 1'b0;
    pc_load = 1'b0;
    dec_bus.instr_ready_in = 1'b1;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL flr_buf_empty: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b1) $display("FAIL flr_refetch_valid: got %0h expected 1", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_addr_out !== 32'h500) $display("FAIL flr_refetch_addr: got %h expected 00000500", mem_bus.imem_req_addr_out); else n_pass++;
    wait_got(base + 1, 20, ok);
    n_chk++; if (!ok) $display("FAIL flr_timeout: got %0d instrs expected 1", got_pc.size() - base); else n_pass++;
    if (ok) begin
      n_chk++; if (got_pc[base] !== 32'h500) $display("FAIL flr_first_pc: got %h expected 00000500", got_pc[base]); else n_pass++;
      n_chk++; if (got_data[base] !== 32'h513) $display("FAIL flr_first_data: got %h expected 00000513", got_data[base]); else n_pass++;
      n_chk++; if (got_cyc[base] != fl_cyc + 5) $display("FAIL flr_first_cycle: got %0d expected %0d", got_cyc[base], fl_cyc + 5); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int base;
    bit ok;
    idle(1);
    load_pc(32'h600);
    mem_bus.imem_req_ready_in = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL arst_instr_valid: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b0) $display("FAIL arst_req_valid: got %0h expected 0", mem_bus.imem_req_valid_out); else n_pass++;
    n_chk++; if (pc_adv !== 1'b0) $display("FAIL arst_pc_advance: got %0h expected 0", pc_adv); else n_pass++;
    n_chk++; if (dec_bus.instr_out !== 32'h0) $display("FAIL arst_instr: got %h expected 00000000", dec_bus.instr_out); else n_pass++;
    n_chk++; if (dec_bus.instr_pc_out !== 32'h0) $display("FAIL arst_instr_pc: got %h expected 00000000", dec_bus.instr_pc_out); else n_pass++;
    tick();
    mem_bus.imem_req_ready_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    spur_req = 1'b1;
    @(negedge clk);
    n_chk++; if (mem_bus.imem_req_valid_out !== 1'b1) $display("FAIL arst_req_after: got %0h expected 1", mem_bus.imem_req_valid_out); else n_pass++;
    tick();
    spur_req = 1'b0;
    @(negedge clk);
    n_chk++; if (dec_bus.instr_valid_out !== 1'b0) $display("FAIL arst_spurious_rsp: got %0h expected 0", dec_bus.instr_valid_out); else n_pass++;
    load_pc(32'h700);
    base = got_pc.size();
    mem_bus.imem_req_ready_in = 1'b1;
    wait_got(base + 1, 12, ok);
    n_chk++; if (!ok) $display("FAIL arst_resume_timeout: got %0d instrs expected 1", got_pc.size() - base); else n_pass++;
    if (ok) begin
      n_chk++; if (got_pc[base] !== 32'h700) $display("FAIL arst_resume_pc: got %h expected 00000700", got_pc[base]); else n_pass++;
      n_chk++; if (got_data[base] !== 32'h713) $display("FAIL arst_resume_data: got %h expected 00000713", got_data[base]); else n_pass++;
    end
  endtask

  initial begin
    mem_bus.imem_req_ready_in = 1'b0;
    dec_bus.instr_ready_in    = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_flush_with_rsp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
